// File: rtl/int_prio_ctrl.sv
// int_prio_ctrl -- registered interrupt priority controller for the Z80 bus.
//
// Purpose:
//   Latches per-channel interrupt requests (edge or level mode), masks them,
//   picks the highest-priority channel (channel 0 highest), drives a registered
//   active-low INT_n to the CPU, and supplies a vector byte during the
//   interrupt-acknowledge cycle. It takes part in a daisy chain via iei/ieo.
//
// Optional feature:
//   NESTED_INT_EN -- when defined, adds an in-service register (register 3).
//   A capture sets ISR[winner], only channels of higher priority than the
//   highest-priority in-service channel may request, ieo is held low while
//   any ISR bit is set, and any write to register 3 is an EOI that clears
//   the highest-priority set ISR bit. When undefined, register 3 reads 0.
//
// Ports:
//   clk_sys   in   1    system clock
//   reset     in   1    synchronous active-high reset
//   irq       in   NCH  active-high request lines (synchronous to clk_sys)
//   iei       in   1    daisy-chain enable in
//   ieo       out  1    daisy-chain enable out (combinational)
//   m1_n      in   1    CPU M1, active low
//   iorq_n    in   1    CPU IORQ, active low (INTA = ~m1_n & ~iorq_n)
//   int_n     out  1    registered interrupt request, active low
//   vect      out  8    vector byte
//   vect_oe   out  1    vector drive enable
//   reg_wr    in   1    register write strobe
//   reg_addr  in   2    register select (0 MASK, 1 PEND, 2 MODE, 3 ISR)
//   reg_din   in   8    register write data
//   reg_dout  out  8    register read data (combinational from reg_addr)

module int_prio_ctrl #(
  parameter int             NCH        = 4,
  parameter logic [7:0]     VEC_BASE   = 8'h00,
  parameter int             VEC_SHIFT  = 1,
  parameter logic [NCH-1:0] RESET_MODE = {NCH{1'b1}}
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [NCH-1:0] irq,
  input  logic           iei,
  output logic           ieo,
  input  logic           m1_n,
  input  logic           iorq_n,
  output logic           int_n,
  output logic [7:0]     vect,
  output logic           vect_oe,
  input  logic           reg_wr,
  input  logic [1:0]     reg_addr,
  input  logic [7:0]     reg_din,
  output logic [7:0]     reg_dout
);

  // Lowest-index set bit of vec: {found, index}.
  function automatic logic [3:0] find_lowest(input logic [NCH-1:0] vec);
    logic [3:0] res;
    res = 4'h0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res = {1'b1, 3'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [NCH-1:0] irq_q_r;
  logic [NCH-1:0] irq_qq_r;
  logic [NCH-1:0] pending_r;
  logic [NCH-1:0] mask_r;
  logic [NCH-1:0] mode_r;
  logic           inta_q_r;
  logic           int_n_r;
  logic [7:0]     vect_r;

  logic           inta_s;
  logic           capture_s;
  logic [NCH-1:0] active_s;
  logic [NCH-1:0] prio_allow_s;
  logic [NCH-1:0] gated_s;
  logic [3:0]     win_s;
  logic [7:0]     vect_calc_s;
  logic [NCH-1:0] set_s;
  logic [NCH-1:0] clr_s;
  logic [NCH-1:0] pending_next_s;
  logic [NCH-1:0] isr_view_s;
  logic           req_s;
  logic [NCH-1:0] rd_s;
  logic           unused_din_s;

  // Upper write-data bits are ignored for NCH < 8.
  assign unused_din_s = ^reg_din;

  assign inta_s    = ~m1_n & ~iorq_n;
  assign capture_s = inta_s & ~inta_q_r;

`ifdef NESTED_INT_EN
  logic [NCH-1:0] isr_r;
  logic [NCH-1:0] eoi_clr_s;
  logic [NCH-1:0] isr_set_s;
  logic [3:0]     eoi_lo_s;

  assign isr_view_s = isr_r;
  assign eoi_lo_s   = find_lowest(isr_r);

  // EOI clears the highest-priority in-service bit; capture marks the winner.
  always_comb begin
    eoi_clr_s = {NCH{1'b0}};
    isr_set_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      eoi_clr_s[i] = reg_wr & (reg_addr == 2'd3) & eoi_lo_s[3] & (eoi_lo_s[2:0] == 3'(i));
      isr_set_s[i] = capture_s & win_s[3] & (win_s[2:0] == 3'(i));
    end
  end

  // In-service register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      isr_r <= {NCH{1'b0}};
    end else begin
      isr_r <= (isr_r & ~eoi_clr_s) | isr_set_s;
    end
  end
`else
  assign isr_view_s = {NCH{1'b0}};
`endif

  // Priority gating: a channel may request only if no in-service bit at its
  // own or a higher-priority index is set.
  always_comb begin
    logic acc;
    acc          = 1'b0;
    prio_allow_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      acc             = acc | isr_view_s[i];
      prio_allow_s[i] = ~acc;
    end
  end

  assign active_s    = pending_r & ~mask_r;
  assign gated_s     = active_s & prio_allow_s;
  assign win_s       = find_lowest(gated_s);
  assign vect_calc_s = VEC_BASE | ({5'b00000, win_s[2:0]} << VEC_SHIFT);
  assign req_s       = iei & (|gated_s);
  assign ieo         = iei & ~(|active_s) & ~(|isr_view_s);

  // Edge detection compares irq_q with its previous value so that edge and
  // level channels both reach pending two edges after irq rises. Clears
  // (PEND write or acknowledge) apply to edge channels only; a set wins.
  always_comb begin
    set_s = irq_q_r & ~irq_qq_r & mode_r;
    clr_s = {NCH{1'b0}};
    if (reg_wr && (reg_addr == 2'd1)) begin
      clr_s = reg_din[NCH-1:0];
    end else begin
      clr_s = {NCH{1'b0}};
    end
    for (int i = 0; i < NCH; i++) begin
      if (capture_s && win_s[3] && (win_s[2:0] == 3'(i))) begin
        clr_s[i] = 1'b1;
      end else begin
        clr_s[i] = clr_s[i];
      end
    end
    clr_s          = clr_s & mode_r;
    pending_next_s = (mode_r & ((pending_r & ~clr_s) | set_s)) | (~mode_r & irq_q_r);
  end

  // Request sampling, pending latches and INT_n.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      irq_q_r   <= {NCH{1'b0}};
      irq_qq_r  <= {NCH{1'b0}};
      pending_r <= {NCH{1'b0}};
      int_n_r   <= 1'b1;
    end else begin
      irq_q_r   <= irq;
      irq_qq_r  <= irq_q_r;
      pending_r <= pending_next_s;
      int_n_r   <= ~req_s;
    end
  end

  // MASK and MODE registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mask_r <= {NCH{1'b1}};
      mode_r <= RESET_MODE;
    end else begin
      if (reg_wr && (reg_addr == 2'd0)) begin
        mask_r <= reg_din[NCH-1:0];
      end else begin
        mask_r <= mask_r;
      end
      if (reg_wr && (reg_addr == 2'd2)) begin
        mode_r <= reg_din[NCH-1:0];
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  // Acknowledge: vector captured on the first INTA cycle; 8'hFF if spurious.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      inta_q_r <= 1'b0;
      vect_r   <= 8'hFF;
    end else begin
      inta_q_r <= inta_s;
      if (capture_s) begin
        vect_r <= win_s[3] ? vect_calc_s : 8'hFF;
      end else begin
        vect_r <= vect_r;
      end
    end
  end

  assign int_n   = int_n_r;
  assign vect    = vect_r;
  assign vect_oe = inta_s & inta_q_r;

  // Register read mux; bits above NCH-1 read zero.
  always_comb begin
    rd_s = {NCH{1'b0}};
    case (reg_addr)
      2'd0:    rd_s = mask_r;
      2'd1:    rd_s = pending_r;
      2'd2:    rd_s = mode_r;
      2'd3:    rd_s = isr_view_s;
      default: rd_s = {NCH{1'b0}};
    endcase
    reg_dout           = 8'h00;
    reg_dout[NCH-1:0]  = rd_s;
  end

endmodule

// File: tb/tb_int_prio_ctrl.sv
module tb_int_prio_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       iei;
  logic       ieo;
  logic       m1_n;
  logic       iorq_n;
  logic       int_n;
  logic [7:0] vect;
  logic       vect_oe;
  logic       reg_wr;
  logic [1:0] reg_addr;
  logic [7:0] reg_din;
  logic [7:0] reg_dout;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] d;

  int_prio_ctrl #(.NCH(4), .VEC_BASE(8'h00), .VEC_SHIFT(1), .RESET_MODE(4'b1111)) dut (
    .clk_sys(clk_sys), .reset(reset), .irq(irq), .iei(iei), .ieo(ieo),
    .m1_n(m1_n), .iorq_n(iorq_n), .int_n(int_n), .vect(vect), .vect_oe(vect_oe),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] v);
    reg_wr = 1'b1; reg_addr = a; reg_din = v;
    cyc();
    reg_wr = 1'b0; reg_din = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    reg_addr = a;
    #1;
    v = reg_dout;
  endtask

  // One-cycle irq pulse followed by enough edges for int_n to react.
  task automatic pulse(input logic [3:0] p);
    irq = p;
    cyc();
    irq = 4'b0000;
    cyc();
    cyc();
  endtask

  // Full INTA cycle; expected vector queued, compared when vect_oe rises.
  task automatic do_inta(input logic [7:0] exp_vec);
    logic got;
    logic [7:0] e;
    got = 1'b0;
    exp_q.push_back(exp_vec);
    m1_n = 1'b0; iorq_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!got) begin
        cyc();
        if (vect_oe === 1'b1) begin
          got = 1'b1;
          e = exp_q.pop_front();
          n_cmp++;
          if (vect !== e) begin
            n_fail++;
            $display("FAIL inta_vect: got %h want %h", vect, e);
          end
        end
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL inta_timeout: vect_oe %b want 1", vect_oe);
      e = exp_q.pop_front();
    end
    cyc();
    m1_n = 1'b1; iorq_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL rst_int_n: got %b want 1", int_n); end
    n_cmp++; if (vect_oe !== 1'b0) begin n_fail++; $display("FAIL rst_vect_oe: got %b want 0", vect_oe); end
    rd(2'd0, d);
    n_cmp++; if (d !== 8'h0F) begin n_fail++; $display("FAIL rst_mask: got %h want 0f", d); end
    rd(2'd2, d);
    n_cmp++; if (d !== 8'h0F) begin n_fail++; $display("FAIL rst_mode: got %h want 0f", d); end
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_pend: got %h want 00", d); end
  endtask

  task automatic test_edge_latency();
    wr_reg(2'd0, 8'h00);
    irq = 4'b0100;
    cyc();
    irq = 4'b0000;
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL lat_pend_k: got %h want 00", d); end
    cyc();
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h04) begin n_fail++; $display("FAIL lat_pend_k1: got %h want 04", d); end
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL lat_int_n_k1: got %b want 1", int_n); end
    cyc();
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL lat_int_n_k2: got %b want 0", int_n); end
    do_inta(8'h04);
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL lat_int_n_after: got %b want 1", int_n); end
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL lat_pend_after: got %h want 00", d); end
  endtask

  task automatic test_priority();
    pulse(4'b1010);
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL prio_int_n: got %b want 0", int_n); end
    do_inta(8'h02);
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL prio_int_n_mid: got %b want 0", int_n); end
    do_inta(8'h06);
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL prio_int_n_end: got %b want 1", int_n); end
  endtask

  task automatic test_level();
    wr_reg(2'd2, 8'h0E);
    irq = 4'b0001;
    cyc(); cyc(); cyc();
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL lvl_int_n: got %b want 0", int_n); end
    do_inta(8'h00);
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL lvl_int_n_after_ack: got %b want 0", int_n); end
    wr_reg(2'd1, 8'h01);
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL lvl_pend_wr: got %h want 01", d); end
    irq = 4'b0000;
    cyc(); cyc(); cyc();
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL lvl_int_n_drop: got %b want 1", int_n); end
    wr_reg(2'd2, 8'h0F);
  endtask

  task automatic test_mask_daisy();
    wr_reg(2'd0, 8'h0F);
    pulse(4'b1000);
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL dc_pend: got %h want 08", d); end
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL dc_masked_int_n: got %b want 1", int_n); end
    n_cmp++; if (ieo !== iei) begin n_fail++; $display("FAIL dc_ieo_pass: got %b want %b", ieo, iei); end
    wr_reg(2'd0, 8'h07);
    n_cmp++; if (ieo !== 1'b0) begin n_fail++; $display("FAIL dc_ieo_block: got %b want 0", ieo); end
    cyc();
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL dc_unmask_int_n: got %b want 0", int_n); end
    iei = 1'b0;
    #1;
    n_cmp++; if (ieo !== 1'b0) begin n_fail++; $display("FAIL dc_ieo_iei0: got %b want 0", ieo); end
    cyc();
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL dc_iei0_int_n: got %b want 1", int_n); end
    iei = 1'b1;
    wr_reg(2'd0, 8'h0F);
    do_inta(8'hFF);
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL dc_spurious_pend: got %h want 08", d); end
    wr_reg(2'd1, 8'h08);
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL dc_pend_clear: got %h want 00", d); end
  endtask

  task automatic test_collision_reset();
    irq = 4'b0010;
    cyc();
    irq = 4'b0000;
    wr_reg(2'd1, 8'h02);
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h02) begin n_fail++; $display("FAIL col_set_wins: got %h want 02", d); end
    wr_reg(2'd1, 8'h02);
    rd(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL col_clear: got %h want 00", d); end
    wr_reg(2'd0, 8'h00);
    pulse(4'b0001);
    m1_n = 1'b0; iorq_n = 1'b0;
    cyc();
    n_cmp++; if (vect_oe !== 1'b1) begin n_fail++; $display("FAIL rstinta_oe_before: got %b want 1", vect_oe); end
    reset = 1'b1;
    cyc();
    rd(2'd0, d);
    n_cmp++; if (vect_oe !== 1'b0) begin n_fail++; $display("FAIL rstinta_oe: got %b want 0", vect_oe); end
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL rstinta_int_n: got %b want 1", int_n); end
    n_cmp++; if (d !== 8'h0F) begin n_fail++; $display("FAIL rstinta_mask: got %h want 0f", d); end
    n_cmp++; if (vect !== 8'hFF) begin n_fail++; $display("FAIL rstinta_vect: got %h want ff", vect); end
    reset = 1'b0;
    m1_n = 1'b1; iorq_n = 1'b1;
    cyc();
  endtask

`ifdef NESTED_INT_EN
  task automatic test_nested();
    wr_reg(2'd0, 8'h00);
    pulse(4'b0100);
    do_inta(8'h04);
    rd(2'd3, d);
    n_cmp++; if (d !== 8'h04) begin n_fail++; $display("FAIL nest_isr1: got %h want 04", d); end
    n_cmp++; if (ieo !== 1'b0) begin n_fail++; $display("FAIL nest_ieo: got %b want 0", ieo); end
    pulse(4'b1000);
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL nest_low_blocked: got %b want 1", int_n); end
    pulse(4'b0001);
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL nest_high_pass: got %b want 0", int_n); end
    do_inta(8'h00);
    rd(2'd3, d);
    n_cmp++; if (d !== 8'h05) begin n_fail++; $display("FAIL nest_isr2: got %h want 05", d); end
    wr_reg(2'd3, 8'h00);
    rd(2'd3, d);
    n_cmp++; if (d !== 8'h04) begin n_fail++; $display("FAIL nest_eoi1: got %h want 04", d); end
    cyc();
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL nest_still_blocked: got %b want 1", int_n); end
    wr_reg(2'd3, 8'h00);
    rd(2'd3, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL nest_eoi2: got %h want 00", d); end
    cyc();
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL nest_ch3_int_n: got %b want 0", int_n); end
    do_inta(8'h06);
    wr_reg(2'd3, 8'h00);
  endtask
`else
  task automatic test_no_isr();
    wr_reg(2'd0, 8'h00);
    pulse(4'b0100);
    do_inta(8'h04);
    wr_reg(2'd3, 8'hFF);
    rd(2'd3, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL noisr_read: got %h want 00", d); end
    pulse(4'b1000);
    n_cmp++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL noisr_no_gate: got %b want 0", int_n); end
    do_inta(8'h06);
  endtask
`endif

  task automatic test_back_to_back();
    wr_reg(2'd0, 8'h00);
    for (int ch = 3; ch >= 0; ch--) begin
      logic [3:0] p;
      p = 4'b0001 << ch;
      pulse(p);
      do_inta(8'(ch << 1));
`ifdef NESTED_INT_EN
      wr_reg(2'd3, 8'h00);
`endif
    end
    n_cmp++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", int_n); end
  endtask

  initial begin
    reset = 1'b1; irq = 4'b0000; iei = 1'b1; m1_n = 1'b1; iorq_n = 1'b1;
    reg_wr = 1'b0; reg_addr = 2'd0; reg_din = 8'h00;
    test_reset();
    test_edge_latency();
    test_priority();
    test_level();
    test_mask_daisy();
    test_collision_reset();
`ifdef NESTED_INT_EN
    test_nested();
`else
    test_no_isr();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
